// File: rtl/rv32i_arb_pkg.sv
// Shared types and constants for the rv32i instruction/data memory arbiter.
package rv32i_arb_pkg;

  localparam int unsigned WDT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } arb_grant_e;

endpackage

// File: rtl/rv32i_arb_wdt.sv
// Transaction watchdog: counts granted cycles without an acknowledge and
// flags expiry when the count equals TIMEOUT (TIMEOUT=0 never expires).
module rv32i_arb_wdt
  import rv32i_arb_pkg::*;
#(
  parameter logic [WDT_W-1:0] TIMEOUT = 16'd1023
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [WDT_W-1:0] count_q;
  logic [WDT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expire = (TIMEOUT != '0) && (count_q == TIMEOUT);

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Fetch/load-store arbiter for a shared stb/ack memory port with watchdog.
// Define RV32I_ARB_RR_EN for round-robin conflict resolution in IDLE.
module rv32i_mem_arbiter
  import rv32i_arb_pkg::*;
#(
  parameter logic [WDT_W-1:0] TIMEOUT  = 16'd1023,
  parameter logic [31:0]      PC_RESET = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_inst_stb,
  input  logic [31:0] i_inst_addr,
  output logic        o_inst_ack,
  output logic [31:0] o_inst_data,
  input  logic        i_data_stb,
  input  logic        i_data_we,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_wsel,
  output logic        o_data_ack,
  output logic [31:0] o_data_rdata,
  output logic        o_mem_stb,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wsel,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_bus_err
);

  arb_state_e  state_q, state_d;
  logic        mem_stb_q, mem_stb_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wsel_q, mem_wsel_d;

  logic in_gnt;
  logic wdt_expire;
  logic timeout;
  logic done;
  logic grant_i;
  logic grant_d;
  logic wdt_en;

  assign in_gnt  = (state_q != ST_IDLE);
  assign timeout = in_gnt && wdt_expire && !i_mem_ack;
  assign done    = in_gnt && (i_mem_ack || timeout);

`ifdef RV32I_ARB_RR_EN
  arb_grant_e last_q, last_d;
`endif

  always_comb begin
    state_d      = state_q;
    mem_stb_d    = mem_stb_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wsel_d   = mem_wsel_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    o_inst_ack   = 1'b0;
    o_inst_data  = '0;
    o_data_ack   = 1'b0;
    o_data_rdata = '0;
`ifdef RV32I_ARB_RR_EN
    last_d       = last_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
`ifdef RV32I_ARB_RR_EN
        if (i_data_stb && i_inst_stb) begin
          grant_d = (last_q == GRANT_INST);
          grant_i = (last_q == GRANT_DATA);
        end else begin
          grant_d = i_data_stb;
          grant_i = i_inst_stb;
        end
`else
        grant_d = i_data_stb;
        grant_i = i_inst_stb && !i_data_stb;
`endif
      end
      ST_GNT_I: begin
        o_inst_ack = i_inst_stb && done;
        if (o_inst_ack && !timeout) begin
          o_inst_data = i_mem_rdata;
        end
        // The just-served requester's stb is ignored: hand off or go idle.
        grant_d = done && i_data_stb;
      end
      ST_GNT_D: begin
        o_data_ack = i_data_stb && done;
        if (o_data_ack && !timeout) begin
          o_data_rdata = i_mem_rdata;
        end
        grant_i = done && i_inst_stb;
      end
      default: ;
    endcase

    if (grant_d) begin
      state_d     = ST_GNT_D;
      mem_stb_d   = 1'b1;
      mem_we_d    = i_data_we;
      mem_addr_d  = i_data_addr;
      mem_wdata_d = i_data_wdata;
      mem_wsel_d  = i_data_wsel;
`ifdef RV32I_ARB_RR_EN
      last_d      = GRANT_DATA;
`endif
    end else if (grant_i) begin
      state_d     = ST_GNT_I;
      mem_stb_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = i_inst_addr;
      mem_wdata_d = '0;
      mem_wsel_d  = '0;
`ifdef RV32I_ARB_RR_EN
      last_d      = GRANT_INST;
`endif
    end else if (done) begin
      state_d   = ST_IDLE;
      mem_stb_d = 1'b0;
    end
  end

  assign wdt_en    = in_gnt && !done;
  assign o_bus_err = timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      mem_stb_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= PC_RESET;
      mem_wdata_q <= '0;
      mem_wsel_q  <= '0;
`ifdef RV32I_ARB_RR_EN
      last_q      <= GRANT_INST;
`endif
    end else begin
      state_q     <= state_d;
      mem_stb_q   <= mem_stb_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wsel_q  <= mem_wsel_d;
`ifdef RV32I_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  rv32i_arb_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (grant_i || grant_d),
    .i_en     (wdt_en),
    .o_expire (wdt_expire)
  );

  assign o_mem_stb   = mem_stb_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wsel  = mem_wsel_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: transaction-level model checked
// every cycle plus directed literal checks.
module tb_rv32i_mem_arbiter;

  localparam logic [31:0] PC_R = 32'h0000_0080;
  localparam int          TO   = 8;
`ifdef RV32I_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_inst_stb = 1'b0;
  logic [31:0] i_inst_addr = '0;
  logic        o_inst_ack;
  logic [31:0] o_inst_data;
  logic        i_data_stb = 1'b0;
  logic        i_data_we = 1'b0;
  logic [31:0] i_data_addr = '0;
  logic [31:0] i_data_wdata = '0;
  logic [3:0]  i_data_wsel = '0;
  logic        o_data_ack;
  logic [31:0] o_data_rdata;
  logic        o_mem_stb;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wsel;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_bus_err;

  int n_cmp = 0;
  int n_err = 0;

  rv32i_mem_arbiter #(
    .TIMEOUT  (16'd8),
    .PC_RESET (PC_R)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_inst_stb   (i_inst_stb),
    .i_inst_addr  (i_inst_addr),
    .o_inst_ack   (o_inst_ack),
    .o_inst_data  (o_inst_data),
    .i_data_stb   (i_data_stb),
    .i_data_we    (i_data_we),
    .i_data_addr  (i_data_addr),
    .i_data_wdata (i_data_wdata),
    .i_data_wsel  (i_data_wsel),
    .o_data_ack   (o_data_ack),
    .o_data_rdata (o_data_rdata),
    .o_mem_stb    (o_mem_stb),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wsel   (o_mem_wsel),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_bus_err    (o_bus_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner 0=none 1=fetch 2=data; waitc = granted cycles without ack.
  int          owner = 0;
  int          waitc = 0;
  int          last  = 1;
  logic        m_stb = 1'b0;
  logic        m_we  = 1'b0;
  logic [31:0] m_addr = PC_R;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wsel = '0;

  int          n_pick = 0;
  bit          n_done = 1'b0;
  bit          n_inc  = 1'b0;
  logic        n_we = 1'b0;
  logic [31:0] n_addr = '0;
  logic [31:0] n_wdata = '0;
  logic [3:0]  n_wsel = '0;

  always @(negedge i_clk) begin
    bit acked, to, done, ia, da;
    int pick;
    acked = (owner != 0) && i_mem_ack;
    to    = (owner != 0) && !i_mem_ack && (waitc == TO);
    done  = acked || to;
    ia    = (owner == 1) && i_inst_stb && done;
    da    = (owner == 2) && i_data_stb && done;
    chk("inst_ack",   {31'b0, o_inst_ack}, {31'b0, ia});
    chk("inst_data",  o_inst_data, (ia && acked) ? i_mem_rdata : 32'h0);
    chk("data_ack",   {31'b0, o_data_ack}, {31'b0, da});
    chk("data_rdata", o_data_rdata, (da && acked) ? i_mem_rdata : 32'h0);
    chk("bus_err",    {31'b0, o_bus_err}, {31'b0, to});
    chk("mem_stb",    {31'b0, o_mem_stb}, {31'b0, m_stb});
    chk("mem_we",     {31'b0, o_mem_we}, {31'b0, m_we});
    chk("mem_addr",   o_mem_addr, m_addr);
    chk("mem_wdata",  o_mem_wdata, m_wdata);
    chk("mem_wsel",   {28'b0, o_mem_wsel}, {28'b0, m_wsel});

    pick = 0;
    if (owner == 0) begin
      if (i_data_stb && i_inst_stb) pick = (RR && last == 2) ? 1 : 2;
      else if (i_data_stb)          pick = 2;
      else if (i_inst_stb)          pick = 1;
    end else if (done) begin
      if (owner == 1 && i_data_stb)      pick = 2;
      else if (owner == 2 && i_inst_stb) pick = 1;
    end
    n_pick  <= pick;
    n_done  <= done;
    n_inc   <= (owner != 0) && !done;
    n_we    <= (pick == 2) ? i_data_we : 1'b0;
    n_addr  <= (pick == 2) ? i_data_addr : i_inst_addr;
    n_wdata <= (pick == 2) ? i_data_wdata : 32'h0;
    n_wsel  <= (pick == 2) ? i_data_wsel : 4'h0;
  end

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner <= 0; waitc <= 0; last <= 1;
      m_stb <= 1'b0; m_we <= 1'b0; m_addr <= PC_R; m_wdata <= '0; m_wsel <= '0;
    end else if (n_pick != 0) begin
      owner <= n_pick; last <= n_pick; waitc <= 0;
      m_stb <= 1'b1; m_we <= n_we; m_addr <= n_addr; m_wdata <= n_wdata; m_wsel <= n_wsel;
    end else if (n_done) begin
      owner <= 0; m_stb <= 1'b0;
    end else if (n_inc) begin
      waitc <= waitc + 1;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1 i_rst_n = 1'b0;
    tick();
    chk("rst_stb",  {31'b0, o_mem_stb}, 32'h0);
    chk("rst_addr", o_mem_addr, 32'h0000_0080);
    i_rst_n = 1'b1;
    tick();

    // Single fetch, memory acks two cycles after stb.
    i_inst_stb = 1'b1; i_inst_addr = 32'h100;
    tick();
    chk("f1_stb",  {31'b0, o_mem_stb}, 32'h1);
    chk("f1_addr", o_mem_addr, 32'h100);
    chk("f1_we",   {31'b0, o_mem_we}, 32'h0);
    tick();
    i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE_0001;
    #1;
    chk("f1_ack",  {31'b0, o_inst_ack}, 32'h1);
    chk("f1_data", o_inst_data, 32'hCAFE_0001);
    tick();
    i_mem_ack = 1'b0; i_inst_stb = 1'b0;
    chk("f1_stb_clr", {31'b0, o_mem_stb}, 32'h0);
    tick();

    // Simultaneous store and fetch: data first, then fetch with no idle gap.
    i_data_stb = 1'b1; i_data_we = 1'b1; i_data_addr = 32'h2000;
    i_data_wdata = 32'hDEAD_BEEF; i_data_wsel = 4'hF;
    i_inst_stb = 1'b1; i_inst_addr = 32'h104;
    tick();
    chk("s2_addr",  o_mem_addr, 32'h2000);
    chk("s2_we",    {31'b0, o_mem_we}, 32'h1);
    chk("s2_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    chk("s2_wsel",  {28'b0, o_mem_wsel}, 32'hF);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h0;
    #1;
    chk("s2_dack", {31'b0, o_data_ack}, 32'h1);
    chk("s2_iack", {31'b0, o_inst_ack}, 32'h0);
    tick();
    i_data_stb = 1'b0; i_data_we = 1'b0; i_mem_ack = 1'b0;
    chk("s2_i_stb",  {31'b0, o_mem_stb}, 32'h1);
    chk("s2_i_addr", o_mem_addr, 32'h104);
    chk("s2_i_we",   {31'b0, o_mem_we}, 32'h0);
    chk("s2_i_wsel", {28'b0, o_mem_wsel}, 32'h0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0013;
    #1;
    chk("s2_i_ack",  {31'b0, o_inst_ack}, 32'h1);
    chk("s2_i_data", o_inst_data, 32'h0000_0013);
    tick();
    i_inst_stb = 1'b0; i_mem_ack = 1'b0;
    tick();

    // Both requesters held with a zero-wait memory: grants alternate D,I,D,I.
    i_data_stb = 1'b1; i_data_addr = 32'h3000;
    i_inst_stb = 1'b1; i_inst_addr = 32'h108;
    i_mem_ack = 1'b1; i_mem_rdata = 32'h55;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("alt_dack", {31'b0, o_data_ack}, (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("alt_iack", {31'b0, o_inst_ack}, (k % 2 == 1) ? 32'h1 : 32'h0);
      tick();
    end
    i_data_stb = 1'b0; i_inst_stb = 1'b0;
    #1;
    chk("alt_drop_ack", {31'b0, o_data_ack}, 32'h0);
    tick();
    i_mem_ack = 1'b0;
    chk("alt_idle", {31'b0, o_mem_stb}, 32'h0);
    tick();

    // Fetch drops stb before the memory acks: ack is discarded.
    i_inst_stb = 1'b1; i_inst_addr = 32'h10C;
    tick();
    i_inst_stb = 1'b0;
    tick();
    i_mem_ack = 1'b1; i_mem_rdata = 32'hBAD0_0BAD;
    #1;
    chk("drop_ack",  {31'b0, o_inst_ack}, 32'h0);
    chk("drop_data", o_inst_data, 32'h0);
    tick();
    i_mem_ack = 1'b0;
    chk("drop_idle", {31'b0, o_mem_stb}, 32'h0);
    tick();

    // Load that never completes: abort on the eighth cycle after grant.
    i_data_stb = 1'b1; i_data_addr = 32'h4000; i_mem_rdata = 32'h1234_5678;
    tick();
    chk("to_stb", {31'b0, o_mem_stb}, 32'h1);
    repeat (7) tick();
    chk("to_early", {31'b0, o_bus_err}, 32'h0);
    tick();
    chk("to_err",   {31'b0, o_bus_err}, 32'h1);
    chk("to_ack",   {31'b0, o_data_ack}, 32'h1);
    chk("to_rdata", o_data_rdata, 32'h0);
    tick();
    i_data_stb = 1'b0;
    chk("to_stb_clr", {31'b0, o_mem_stb}, 32'h0);
    chk("to_err_clr", {31'b0, o_bus_err}, 32'h0);
    tick();

    // Ack arrives exactly at the timeout count: ack wins, no error.
    i_data_stb = 1'b1; i_data_addr = 32'h4004;
    tick();
    repeat (8) tick();
    i_mem_ack = 1'b1; i_mem_rdata = 32'h77;
    #1;
    chk("co_err",   {31'b0, o_bus_err}, 32'h0);
    chk("co_ack",   {31'b0, o_data_ack}, 32'h1);
    chk("co_rdata", o_data_rdata, 32'h77);
    tick();
    i_data_stb = 1'b0; i_mem_ack = 1'b0;
    tick();

    // Asynchronous reset during a store grant, then a normal fetch.
    i_data_stb = 1'b1; i_data_we = 1'b1; i_data_addr = 32'h5000;
    i_data_wdata = 32'h0000_A5A5; i_data_wsel = 4'h3;
    tick();
    tick();
    #2;
    i_rst_n = 1'b0; i_data_stb = 1'b0; i_data_we = 1'b0;
    #1;
    chk("ar_stb",   {31'b0, o_mem_stb}, 32'h0);
    chk("ar_addr",  o_mem_addr, 32'h0000_0080);
    chk("ar_we",    {31'b0, o_mem_we}, 32'h0);
    chk("ar_wdata", o_mem_wdata, 32'h0);
    chk("ar_wsel",  {28'b0, o_mem_wsel}, 32'h0);
    chk("ar_dack",  {31'b0, o_data_ack}, 32'h0);
    tick();
    i_rst_n = 1'b1;
    tick();
    i_inst_stb = 1'b1; i_inst_addr = 32'h200;
    tick();
    chk("ar_f_stb",  {31'b0, o_mem_stb}, 32'h1);
    chk("ar_f_addr", o_mem_addr, 32'h200);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h99;
    #1;
    chk("ar_f_ack", {31'b0, o_inst_ack}, 32'h1);
    tick();
    i_inst_stb = 1'b0; i_mem_ack = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
